// File: rtl/bus_pipe_pkg.sv
// Shared constants and the entry-op helper for the bus_pipe_reg pipeline.
// The op helper works on the widest legal bus; callers truncate to their width.
package bus_pipe_pkg;

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_AND  = 2'b01;
  localparam logic [1:0] OP_OR   = 2'b10;
  localparam logic [1:0] OP_INV  = 2'b11;

  localparam int DATA_W_MIN = 1;
  localparam int DATA_W_MAX = 64;
  localparam int DEPTH_MIN  = 1;
  localparam int DEPTH_MAX  = 8;

  function automatic logic [DATA_W_MAX-1:0] apply_op(
    input logic [1:0]            op,
    input logic [DATA_W_MAX-1:0] a,
    input logic [DATA_W_MAX-1:0] b
  );
    logic [DATA_W_MAX-1:0] r;
    case (op)
      OP_PASS: r = a;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      default: r = ~a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bus_pipe_stage.sv
// One elastic register slice: holds a beat (data + flag) and its valid bit.
// The slice's own ready is computed by the parent so the ready chain stays loop-free.
module bus_pipe_stage
  import bus_pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rdy,
  input  logic         up_valid,
  input  logic [W-1:0] up_data,
  input  logic         up_flag,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         flag
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         flag_q, flag_d;

  // When ready, the held beat (if any) is leaving, so valid follows upstream.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    flag_d  = flag_q;
    if (rdy) begin
      valid_d = up_valid;
      if (up_valid) begin
        data_d = up_data;
        flag_d = up_flag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      flag_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      flag_q  <= flag_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign flag  = flag_q;

endmodule

// File: rtl/bus_pipe_reg.sv
// Elastic bus pipeline: applies a logic op at entry, carries data+flag through
// DEPTH valid/ready slices, and counts beats delivered to the sink.
module bus_pipe_reg
  import bus_pipe_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] mask,
  input  logic [1:0]        op,
  input  logic              sel,
  input  logic              en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] dout,
  output logic              flag,
  output logic [CNT_W-1:0]  beat_cnt
);

  if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX ||
      DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_param_err
    $error("bus_pipe_reg: DATA_W or DEPTH out of legal range");
  end

  logic [DATA_W-1:0] res;
  logic              flag_in;
  logic [DEPTH-1:0]  vld_p;
  logic [DATA_W-1:0] data_p [DEPTH];
  logic [DEPTH-1:0]  flag_p;
  logic [DEPTH-1:0]  rdy;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;

  always_comb begin
    res     = DATA_W'(apply_op(op, DATA_W_MAX'(din), DATA_W_MAX'(mask)));
    flag_in = sel | (res[0] & en);
  end

  // A stage is ready if it or any stage downstream has a hole, or the sink takes.
  // Written without reference to other ready bits to keep the chain acyclic.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      rdy[k] = out_ready;
      for (int j = k; j < DEPTH; j++) begin
        if (!vld_p[j]) rdy[k] = 1'b1;
      end
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      bus_pipe_stage #(.W(DATA_W)) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .rdy      (rdy[k]),
        .up_valid (in_valid),
        .up_data  (res),
        .up_flag  (flag_in),
        .valid    (vld_p[k]),
        .data     (data_p[k]),
        .flag     (flag_p[k])
      );
    end else begin : g_body
      bus_pipe_stage #(.W(DATA_W)) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .rdy      (rdy[k]),
        .up_valid (vld_p[k-1]),
        .up_data  (data_p[k-1]),
        .up_flag  (flag_p[k-1]),
        .valid    (vld_p[k]),
        .data     (data_p[k]),
        .flag     (flag_p[k])
      );
    end
  end

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (vld_p[DEPTH-1] && out_ready) beat_cnt_d = beat_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) beat_cnt_q <= '0;
    else        beat_cnt_q <= beat_cnt_d;
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld_p[DEPTH-1];
  assign dout      = data_p[DEPTH-1];
  assign flag      = flag_p[DEPTH-1];
  assign beat_cnt  = beat_cnt_q;

endmodule
